// File: rtl/arb_pkg.sv
// Shared arbiter-chain definitions: FSM state enum, default sizing and a one-hot check.
package arb_pkg;

  localparam int unsigned N_DEF        = 4;
  localparam int unsigned ARB_LAT_DEF  = 2;
  localparam int unsigned MAX_HOLD_DEF = 16;
  localparam int unsigned VEC_MAX_W    = 32;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    SAMPLE = 2'd1,
    OWN    = 2'd2
  } state_e;

  // True when exactly one bit of v is set; callers zero-extend narrower vectors.
  function automatic logic onehot(input logic [VEC_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - VEC_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/onehot_enc.sv
// One-hot to binary encoder with one-hot / all-zero flags, shared by arbiter stages.
module onehot_enc
  import arb_pkg::*;
#(
  parameter  int unsigned N     = N_DEF,
  localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic [PTR_W-1:0] idx_c,
  output logic             is_onehot_c,
  output logic             is_zero_c
);

  // OR of set-bit indices; exact whenever vec is one-hot.
  always_comb begin
    idx_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) idx_c = idx_c | PTR_W'(i);
    end
  end

  assign is_onehot_c = onehot(VEC_MAX_W'(vec));
  assign is_zero_c   = (vec == '0);

endmodule

// File: rtl/rr_grant_ctrl.sv
// Round-robin grant holder behind mask_arbiter: latches one owner, holds it until
// done / request drop / timeout, then rotates ptr to owner+1 for the arbiter.
module rr_grant_ctrl
  import arb_pkg::*;
#(
  parameter  int unsigned N        = N_DEF,
  parameter  int unsigned ARB_LAT  = ARB_LAT_DEF,
  parameter  int unsigned MAX_HOLD = MAX_HOLD_DEF,
  localparam int unsigned PTR_W    = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     arb_grant,
  input  logic             done,
  output logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic             timeout,
  output logic             err_multi
);

  localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned SET_W  = $clog2(ARB_LAT + 1);

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_cnt, settle_d;
  logic [HOLD_W-1:0]  hold_cnt, hold_d;
  logic [N-1:0]       gnt_d;
  logic [PTR_W-1:0]   ptr_d;
  logic               gnt_valid_d, timeout_d, err_d;

  logic [PTR_W-1:0]   arb_idx, owner_idx;
  logic               arb_onehot, arb_zero, gnt_onehot, gnt_zero;
  logic               owner_req, hit_max;

  onehot_enc #(.N(N)) u_arb_enc (
    .vec         (arb_grant),
    .idx_c       (arb_idx),
    .is_onehot_c (arb_onehot),
    .is_zero_c   (arb_zero)
  );

  onehot_enc #(.N(N)) u_own_enc (
    .vec         (gnt),
    .idx_c       (owner_idx),
    .is_onehot_c (gnt_onehot),
    .is_zero_c   (gnt_zero)
  );

  assign owner_req = |(req & gnt);
  assign hit_max   = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= SETTLE;
      settle_cnt <= '0;
      hold_cnt   <= '0;
      gnt        <= '0;
      gnt_valid  <= 1'b0;
      ptr        <= '0;
      timeout    <= 1'b0;
      err_multi  <= 1'b0;
    end else begin
      state_q    <= state_d;
      settle_cnt <= settle_d;
      hold_cnt   <= hold_d;
      gnt        <= gnt_d;
      gnt_valid  <= gnt_valid_d;
      ptr        <= ptr_d;
      timeout    <= timeout_d;
      err_multi  <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_cnt;
    hold_d      = hold_cnt;
    gnt_d       = gnt;
    gnt_valid_d = gnt_valid;
    ptr_d       = ptr;
    timeout_d   = 1'b0;
    err_d       = err_multi;

    case (state_q)
      SETTLE: begin
        if (settle_cnt == SET_W'(ARB_LAT)) state_d = SAMPLE;
        else                              settle_d = settle_cnt + SET_W'(1);
      end

      SAMPLE: begin
        if (!arb_zero) begin
          if (!arb_onehot) begin
            err_d = 1'b1;
          end else if (req[arb_idx]) begin
            gnt_d       = arb_grant;
            gnt_valid_d = 1'b1;
            hold_d      = '0;
            state_d     = OWN;
          end
        end
      end

      OWN: begin
        if (!hit_max) hold_d = hold_cnt + HOLD_W'(1);
        if (done || !owner_req || hit_max) begin
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          ptr_d       = (owner_idx == PTR_W'(N - 1)) ? '0 : owner_idx + PTR_W'(1);
          settle_d    = '0;
          state_d     = SETTLE;
          timeout_d   = hit_max && !done && owner_req;
        end
      end

      default: begin
        state_d  = SETTLE;
        settle_d = '0;
      end
    endcase
  end

  // The held grant is one-hot exactly when it is flagged valid.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) gnt_valid |-> gnt_onehot);
  a_gnt_zero:   assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == !gnt_zero);

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Bench for rr_grant_ctrl: directed scenarios with literal expectations, then random
// traffic compared every cycle against a behavioural ownership model.
module tb_rr_grant_ctrl;

  localparam int N        = 4;
  localparam int ARB_LAT  = 2;
  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, arb_grant;
  logic       done;
  logic [1:0] ptr;
  logic [3:0] gnt;
  logic       gnt_valid, timeout, err_multi;

  int n_chk  = 0;
  int n_fail = 0;
  bit en     = 1'b0;

  rr_grant_ctrl #(.N(N), .ARB_LAT(ARB_LAT), .MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .arb_grant (arb_grant),
    .done      (done),
    .ptr       (ptr),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout),
    .err_multi (err_multi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the resource, how long, how many blind cycles remain after a release.
  int m_owner = -1;
  int m_held  = 0;
  int m_blind = 0;
  int m_ptr   = 0;
  bit m_err   = 1'b0;
  bit m_to    = 1'b0;

  always @(posedge clk) begin
    int ones, idx;
    if (!rst_n) begin
      m_owner = -1; m_held = 0; m_blind = ARB_LAT + 1;
      m_ptr = 0; m_err = 1'b0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        if (done || !req[m_owner] || m_held == MAX_HOLD) begin
          m_to    = (m_held == MAX_HOLD) && !done && req[m_owner];
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
          m_blind = ARB_LAT + 1;
        end else begin
          m_held++;
        end
      end else if (m_blind > 0) begin
        m_blind--;
      end else begin
        ones = 0; idx = 0;
        for (int i = 0; i < N; i++) if (arb_grant[i]) begin ones++; idx = i; end
        if (ones > 1) m_err = 1'b1;
        else if (ones == 1 && req[idx]) begin m_owner = idx; m_held = 1; end
      end
    end
  end

  // Per-cycle comparison plus a release-to-regrant gap check.
  int  low_run  = 0;
  bit  prev_vld = 1'b0;
  bit  saw_fall = 1'b0;
  always @(negedge clk) begin
    if (en) begin
      chk("gnt_valid", gnt_valid, (m_owner >= 0));
      chk("gnt",       gnt,       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("ptr",       ptr,       m_ptr);
      chk("timeout",   timeout,   m_to);
      chk("err_multi", err_multi, m_err);
      if (prev_vld && !gnt_valid) begin saw_fall = 1'b1; low_run = 0; end
      if (!gnt_valid) low_run++;
      if (!prev_vld && gnt_valid && saw_fall) chk("regrant_gap_ok", (low_run >= ARB_LAT + 1), 1);
      prev_vld = gnt_valid;
    end
  end

  task automatic drive(input logic [3:0] r, input logic [3:0] a, input logic d);
    req = r; arb_grant = a; done = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return 4'(1 << ((p + k) % N));
    end
    return 4'b0000;
  endfunction

  initial begin
    int hi;
    logic [3:0] r_cur, a;
    int sel;
    rst_n = 1'b0; req = '0; arb_grant = '0; done = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0);
    en = 1'b1;
    chk("rst_gnt", gnt, 0); chk("rst_valid", gnt_valid, 0);
    chk("rst_ptr", ptr, 0); chk("rst_err", err_multi, 0); chk("rst_to", timeout, 0);
    rst_n = 1'b1;

    // Reset while owning 4'b0100.
    repeat (3) drive(4'b0100, 4'b0000, 1'b0);
    chk("t1_settle_valid", gnt_valid, 0);
    drive(4'b0100, 4'b0100, 1'b0);
    chk("t1_gnt", gnt, 4'b0100); chk("t1_valid", gnt_valid, 1);
    repeat (2) drive(4'b0100, 4'b0000, 1'b0);
    rst_n = 1'b0;
    drive(4'b0100, 4'b0100, 1'b0);
    chk("t1_rst_gnt", gnt, 0); chk("t1_rst_valid", gnt_valid, 0);
    chk("t1_rst_ptr", ptr, 0); chk("t1_rst_err", err_multi, 0);
    rst_n = 1'b1;

    // Owner 1 held three cycles, released by done.
    repeat (3) drive(4'b0110, 4'b0000, 1'b0);
    drive(4'b0110, 4'b0010, 1'b0);
    chk("t2_gnt_c1", gnt, 4'b0010);
    repeat (2) begin drive(4'b0110, 4'b0010, 1'b0); chk("t2_gnt_hold", gnt, 4'b0010); end
    drive(4'b0110, 4'b0010, 1'b1);
    chk("t2_rel_valid", gnt_valid, 0); chk("t2_ptr", ptr, 2);
    repeat (3) begin drive(4'b0110, 4'b0010, 1'b0); chk("t2_gap_valid", gnt_valid, 0); end
    drive(4'b0110, 4'b0010, 1'b0);
    chk("t2_regrant", gnt_valid, 1);
    drive(4'b0110, 4'b0000, 1'b1);

    // Owner 3 wraps ptr to 0.
    repeat (3) drive(4'b1000, 4'b0000, 1'b0);
    drive(4'b1000, 4'b1000, 1'b0);
    chk("t3_gnt", gnt, 4'b1000);
    drive(4'b1000, 4'b0000, 1'b1);
    chk("t3_ptr_wrap", ptr, 0); chk("t3_valid", gnt_valid, 0);

    // Owner 0 never finishes: forced release after MAX_HOLD cycles.
    repeat (3) drive(4'b0001, 4'b0000, 1'b0);
    drive(4'b0001, 4'b0001, 1'b0);
    hi = int'(gnt_valid);
    repeat (MAX_HOLD - 1) begin
      drive(4'b0001, 4'b0000, 1'b0);
      hi += int'(gnt_valid);
      chk("t4_no_early_to", timeout, 0);
    end
    drive(4'b0001, 4'b0000, 1'b0);
    chk("t4_rel_valid", gnt_valid, 0); chk("t4_timeout", timeout, 1);
    chk("t4_ptr", ptr, 1); chk("t4_hold_cycles", hi, MAX_HOLD);
    drive(4'b0001, 4'b0000, 1'b0);
    chk("t4_to_pulse", timeout, 0);

    // done and request drop together: one release, no timeout.
    repeat (2) drive(4'b0100, 4'b0000, 1'b0);
    drive(4'b0100, 4'b0100, 1'b0);
    chk("t5_gnt", gnt, 4'b0100);
    drive(4'b0000, 4'b0000, 1'b1);
    chk("t5_valid", gnt_valid, 0); chk("t5_to", timeout, 0); chk("t5_ptr", ptr, 3);

    // Multi-hot flags error; stale one-hot ignored; clean one-hot captured.
    repeat (3) drive(4'b0011, 4'b0000, 1'b0);
    drive(4'b0011, 4'b0011, 1'b0);
    chk("t6_no_capture", gnt_valid, 0); chk("t6_err", err_multi, 1);
    drive(4'b0010, 4'b0001, 1'b0);
    chk("t6_stale", gnt_valid, 0); chk("t6_err_sticky", err_multi, 1);
    drive(4'b0011, 4'b0001, 1'b0);
    chk("t6_gnt", gnt, 4'b0001); chk("t6_valid", gnt_valid, 1); chk("t6_err_hold", err_multi, 1);
    drive(4'b0000, 4'b0000, 1'b0);
    chk("t6_ptr", ptr, 1);

    // Random traffic with occasional resets.
    rst_n = 1'b0;
    drive(4'b0000, 4'b0000, 1'b0);
    rst_n = 1'b1;
    r_cur = 4'($urandom);
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) r_cur[$urandom_range(0, 3)] = ~r_cur[$urandom_range(0, 3)];
      sel = int'($urandom_range(0, 19));
      if (sel < 12)      a = rr_pick(r_cur, m_ptr);
      else if (sel < 14) a = 4'b0000;
      else if (sel < 15) a = 4'($urandom);
      else               a = 4'(1 << $urandom_range(0, 3));
      drive(r_cur, a, ($urandom_range(0, 11) == 0));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
